bp_update_ctrl: RTL and testbench

Controller for the fetch-stage branch predictor tables (128-entry target buffer, tag array, 2-bit counters). Sits between the EX stage and the predictor's single table write port. Compares each resolved branch/jump against the PC predicted at fetch and raises an immediate redirect on mismatch. Buffers training writes in a small FIFO and, after every reset, sequences a full clear sweep of the tables, arbitrating that sweep against the FIFO for the write port.

---
 rtl/bp_update_ctrl_pkg.sv | 27 ++
 rtl/bp_upd_fifo.sv | 52 +++++
 rtl/bp_update_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor update controller.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Holds the control-instruction kind codes, the default table geometry,
// the controller FSM state encoding and a kind-qualification helper.
package bp_update_ctrl_pkg;

    localparam int IDX_W_DEF      = 7;
    localparam int TAG_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [1:0] KIND_BR  = 2'b01;
    localparam logic [1:0] KIND_JMP = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } bp_state_t;

    // Only branches and jumps train the tables; every other code is ignored.
    function automatic logic kind_valid(input logic [1:0] kind);
        return (kind == KIND_BR) || (kind == KIND_JMP);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO buffering predictor training writes.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
//
// Ports: clk/rst_n (async active-low), push/push_dat, pop/pop_dat, full, empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits match.
module bp_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_dat;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor update controller: mispredict redirect, training FIFO, post-reset table clear.
// Latency: redirect same cycle as ex_valid; queued update reaches upd_* one cycle or more later.
// Backpressure: stall_req when the FIFO is full or before init starts; upd_* held while upd_we & ~upd_ready.
//
// Ports: clk, rst_n (async active-low); ex_* resolved control instruction from EX;
// redirect/redirect_pc to fetch; stall_req to EX; init_busy to fetch;
// upd_* table write port with upd_ready handshake.
// Optional macro PRED_STATS_EN adds branch_cnt/mispred_cnt statistics outputs.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [1:0]       ex_kind,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pred_pc,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             stall_req,
    output logic             init_busy,
    output logic             upd_we,
    input  logic             upd_ready,
    output logic             upd_clear,
    output logic [IDX_W-1:0] upd_idx,
    output logic [TAG_W-1:0] upd_tag,
    output logic [1:0]       upd_kind,
    output logic             upd_taken,
    output logic [31:0]      upd_target
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
`endif
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [1:0]       kind;
        logic             taken;
        logic [31:0]      target;
    } upd_ent_t;

    localparam int ENT_W = $bits(upd_ent_t);

    bp_state_t        state;
    logic [IDX_W-1:0] sweep_cnt;

    logic             vld_kind;
    logic [31:0]      pc_plus4;
    logic [31:0]      actual_pc;
    logic             mispredict;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    upd_ent_t         push_ent;
    upd_ent_t         head_ent;
    logic [ENT_W-1:0] head_dat;
    logic             sweep_last;

    // ------------------------------------------------------------------
    // Resolution and mispredict detection
    // ------------------------------------------------------------------
    assign vld_kind   = ex_valid && kind_valid(ex_kind);
    assign pc_plus4   = ex_pc + 32'd4;
    assign actual_pc  = ((ex_kind == KIND_JMP) || ex_taken) ? ex_target : pc_plus4;
    assign mispredict = vld_kind && (actual_pc != ex_pred_pc);

    // Before the first post-reset edge nothing can be captured, so EX is held.
    assign stall_req   = vld_kind && (fifo_full || (state == ST_WAIT));
    // A stalled instruction will re-present next cycle; redirect only once.
    assign redirect    = mispredict && !stall_req && (state != ST_WAIT);
    assign redirect_pc = actual_pc;
    assign init_busy   = (state != ST_RUN);

    // ------------------------------------------------------------------
    // Training FIFO
    // ------------------------------------------------------------------
    assign fifo_push       = vld_kind && !fifo_full && (state != ST_WAIT);
    assign push_ent.idx    = ex_pc[IDX_W-1:0];
    assign push_ent.tag    = ex_pc[IDX_W+TAG_W-1:IDX_W];
    assign push_ent.kind   = ex_kind;
    assign push_ent.taken  = ex_taken;
    assign push_ent.target = ex_target;

    // Only the RUN phase drains the queue; during the sweep it only fills.
    assign fifo_pop = (state == ST_RUN) && !fifo_empty && upd_ready;
    assign head_ent = upd_ent_t'(head_dat);

    bp_upd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM and clear-sweep counter
    // ------------------------------------------------------------------
    assign sweep_last = (sweep_cnt == {IDX_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            sweep_cnt <= '0;
        end else begin
            case (state)
                ST_WAIT: state <= ST_INIT;
                ST_INIT: begin
                    if (upd_ready) begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                        if (sweep_last) state <= ST_RUN;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_WAIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-port arbitration: sweep owns the port in INIT, FIFO in RUN.
    // Both sources only change on an accepted write, so upd_* hold while
    // the predictor is not ready.
    // ------------------------------------------------------------------
    always_comb begin
        upd_we     = 1'b0;
        upd_clear  = 1'b0;
        upd_idx    = '0;
        upd_tag    = '0;
        upd_kind   = 2'b00;
        upd_taken  = 1'b0;
        upd_target = '0;
        case (state)
            ST_INIT: begin
                upd_we    = 1'b1;
                upd_clear = 1'b1;
                upd_idx   = sweep_cnt;
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    upd_we     = 1'b1;
                    upd_idx    = head_ent.idx;
                    upd_tag    = head_ent.tag;
                    upd_kind   = head_ent.kind;
                    upd_taken  = head_ent.taken;
                    upd_target = head_ent.target;
                end
            end
            default: ;
        endcase
    end

`ifdef PRED_STATS_EN
    // ------------------------------------------------------------------
    // Statistics (wrap-around)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (fifo_push) branch_cnt  <= branch_cnt + 32'd1;
            if (redirect)  mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  ex_kind;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_req;
    logic        init_busy;
    logic        upd_we;
    logic        upd_ready;
    logic        upd_clear;
    logic [6:0]  upd_idx;
    logic [7:0]  upd_tag;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
`ifdef PRED_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
`endif

    int total = 0;
    int bad   = 0;

    bp_update_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_kind     (ex_kind),
        .ex_pc       (ex_pc),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .ex_pred_pc  (ex_pred_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_req   (stall_req),
        .init_busy   (init_busy),
        .upd_we      (upd_we),
        .upd_ready   (upd_ready),
        .upd_clear   (upd_clear),
        .upd_idx     (upd_idx),
        .upd_tag     (upd_tag),
        .upd_kind    (upd_kind),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
`ifdef PRED_STATS_EN
        ,
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [1:0] k, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt, input logic [31:0] pred);
        ex_valid   = v;
        ex_kind    = k;
        ex_pc      = pc;
        ex_taken   = tk;
        ex_target  = tgt;
        ex_pred_pc = pred;
    endtask

    initial begin
        rst_n     = 1'b0;
        upd_ready = 1'b1;
        drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Reset values
        check("rst_redirect",  redirect,   32'h0);
        check("rst_stall",     stall_req,  32'h0);
        check("rst_init_busy", init_busy,  32'h1);
        check("rst_upd_we",    upd_we,     32'h0);
        check("rst_upd_clear", upd_clear,  32'h0);
        check("rst_upd_idx",   upd_idx,    32'h0);
        check("rst_upd_tag",   upd_tag,    32'h0);
        check("rst_upd_tgt",   upd_target, 32'h0);

        // WAIT: a valid branch must stall and never redirect
        rst_n = 1'b1;
        drive_ex(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 32'h104);
        #1;
        check("wait_stall",    stall_req,  32'h1);
        check("wait_redirect", redirect,   32'h0);
        check("wait_upd_we",   upd_we,     32'h0);
        step();
        drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);

        // INIT: 128 consecutive clears; a jump queued at sweep idx 5
        for (int i = 0; i < 128; i++) begin
            if (i == 5) drive_ex(1'b1, 2'b10, 32'h305, 1'b0, 32'h400, 32'h309);
            if (i == 6) drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
            #1;
            check("init_idx",   upd_idx,   i);
            check("init_clear", upd_clear, 32'h1);
            check("init_we",    upd_we,    32'h1);
            check("init_busy",  init_busy, 32'h1);
            if (i == 5) begin
                check("init_jmp_redirect", redirect,    32'h1);
                check("init_jmp_rpc",      redirect_pc, 32'h400);
                check("init_jmp_stall",    stall_req,   32'h0);
            end
            step();
        end

        // RUN: queued jump is written right after the last clear
        check("run_init_busy", init_busy,  32'h0);
        check("jmp_we",        upd_we,     32'h1);
        check("jmp_clear",     upd_clear,  32'h0);
        check("jmp_kind",      upd_kind,   32'h2);
        check("jmp_idx",       upd_idx,    32'h5);
        check("jmp_tag",       upd_tag,    32'h6);
        check("jmp_target",    upd_target, 32'h400);
        step();
        check("jmp_drained",   upd_we,     32'h0);

        // Taken branch, mispredicted
        drive_ex(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 32'h104);
        #1;
        check("br1_redirect", redirect,    32'h1);
        check("br1_rpc",      redirect_pc, 32'h80);
        check("br1_stall",    stall_req,   32'h0);
        step();
        drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        check("br1_we",     upd_we,     32'h1);
        check("br1_idx",    upd_idx,    32'h0);
        check("br1_tag",    upd_tag,    32'h2);
        check("br1_taken",  upd_taken,  32'h1);
        check("br1_kind",   upd_kind,   32'h1);
        check("br1_target", upd_target, 32'h80);
        step();
        check("br1_drained", upd_we, 32'h0);

        // Not-taken branch, correctly predicted
        drive_ex(1'b1, 2'b01, 32'h200, 1'b0, 32'h999, 32'h204);
        #1;
        check("br2_redirect", redirect,    32'h0);
        check("br2_rpc",      redirect_pc, 32'h204);
        step();
        drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        check("br2_we",    upd_we,    32'h1);
        check("br2_taken", upd_taken, 32'h0);
        check("br2_tag",   upd_tag,   32'h4);
        step();
        check("br2_drained", upd_we, 32'h0);

        // Ignored kind code: no redirect, no stall, nothing queued
        drive_ex(1'b1, 2'b11, 32'h300, 1'b1, 32'h500, 32'h304);
        #1;
        check("k11_redirect", redirect,  32'h0);
        check("k11_stall",    stall_req, 32'h0);
        step();
        drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        check("k11_no_write", upd_we, 32'h0);

        // Fill the FIFO with the write port blocked
        upd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_ex(1'b1, 2'b01, (k + 1) * 32'h10, 1'b1, 32'h1000 + k, (k + 1) * 32'h10 + 32'h4);
            #1;
            check("fill_stall",    stall_req, 32'h0);
            check("fill_redirect", redirect,  32'h1);
            if (k > 0) check("fill_hold_idx", upd_idx, 32'h10);
            step();
        end
        // 5th branch hits a full FIFO; a same-cycle pop does not free a slot
        drive_ex(1'b1, 2'b01, 32'h50, 1'b1, 32'h1004, 32'h54);
        upd_ready = 1'b1;
        #1;
        check("full_stall",    stall_req,   32'h1);
        check("full_redirect", redirect,    32'h0);
        check("full_rpc",      redirect_pc, 32'h1004);
        check("full_head",     upd_idx,     32'h10);
        step();
        check("free_stall",    stall_req, 32'h0);
        check("free_redirect", redirect,  32'h1);
        check("drain_idx_20",  upd_idx,   32'h20);
        step();
        drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        check("drain_idx_30", upd_idx, 32'h30);
        step();
        check("drain_idx_40", upd_idx, 32'h40);
        step();
        check("drain_idx_50", upd_idx,    32'h50);
        check("drain_tgt_50", upd_target, 32'h1004);
        step();
        check("drain_empty", upd_we, 32'h0);

`ifdef PRED_STATS_EN
        check("stat_branch",  branch_cnt,  32'd8);
        check("stat_mispred", mispred_cnt, 32'd7);
`endif

        // Reset mid-sweep with two queued updates
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            if (i == 1) drive_ex(1'b1, 2'b01, 32'h7, 1'b1, 32'h900, 32'hb);
            if (i == 2) drive_ex(1'b1, 2'b10, 32'h8, 1'b0, 32'h904, 32'hc);
            if (i == 3) drive_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
            step();
        end
        check("mid_idx_40", upd_idx, 32'd40);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",   upd_we,    32'h0);
        check("mid_rst_idx",  upd_idx,   32'h0);
        check("mid_rst_busy", init_busy, 32'h1);
`ifdef PRED_STATS_EN
        check("mid_rst_stat", branch_cnt, 32'h0);
`endif
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 128; i++) begin
            check("resweep_idx", upd_idx, i);
            step();
        end
        check("resweep_busy",  init_busy, 32'h0);
        check("resweep_empty", upd_we,    32'h0);
        step();
        check("resweep_still_empty", upd_we, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
